stroke_ratio_tracker: RTL and testbench
=======================================

# stroke_ratio_tracker

Parametrised successor to the single-stroke drive/recovery ratio counter in the erg datapath. It tracks the IDLE/DRIVE/RECOVERY phases from the `start_drive` and `start_recovery` pulses. On each completed stroke it computes recovery/drive as an unsigned fixed-point ratio using a bit-serial divider. It also keeps a moving average over the last 2^AVG_LOG2 strokes, with saturation, idle timeout and drop reporting, and feeds the display/stats logic.

## Interface
- COUNT_W, 16: phase counter width. Saturates at all-ones.
- FRAC_W, 8: fractional bits of ratio. COUNT_W+FRAC_W ≤ 32.
- AVG_LOG2, 2: averaging window is N = 2^AVG_LOG2 strokes.

- count_clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- start_drive  in  1  pulse, drive phase begins
- start_recovery  in  1  pulse, recovery phase begins
- ratio  out  32  last stroke ratio, floor(rec·2^FRAC_W/drv), zero-extended
- avg_ratio  out  32  floor(sum of last N ratios / N)
- ratio_valid  out  1  one-cycle pulse when ratio/avg_ratio update
- stroke_count  out  16  completed strokes, wraps 0xFFFF→0
- on_drive  out  1  state == DRIVE
- busy  out  1  divider running
- overflow  out  1  sticky, phase counter saturated
- dropped  out  1  one-cycle pulse, stroke completed while busy

## Operation
- Reset (reset_n low at an edge) sets state=IDLE and clears all outputs to 0. It clears drive_cnt, rec_cnt, the divider and the history buffer, and marks the buffer unprimed. This applies mid-division too: the result is discarded.
- States:
  - IDLE: start_drive → DRIVE with drive_cnt←1.
  - DRIVE: increments drive_cnt each edge. start_recovery → RECOVERY with rec_cnt←1. start_drive is ignored.
  - RECOVERY: increments rec_cnt each edge. start_drive completes the stroke → DRIVE with drive_cnt←1. start_recovery is ignored.
- Priority when both pulses are high: the current state decides, so the same rules above apply. IDLE→DRIVE, DRIVE→RECOVERY, RECOVERY→stroke complete.
- Count semantics: start_drive at edge t0, start_recovery at t1, start_drive at t2 gives drive=t1−t0, recovery=t2−t1. Both are always ≥1, so there is no divide-by-zero.
- Saturation/timeout: if either counter reaches 2^COUNT_W−1, the state goes to IDLE at that edge. overflow←1 (cleared only by reset), no ratio is produced, and the buffer becomes unprimed.
- Stroke complete, not busy: drive and recovery values are latched and busy←1. The restoring divider computes (rec<<FRAC_W)/drv, one quotient bit per cycle, Q=COUNT_W+FRAC_W cycles.
- Stroke complete while busy: counts are discarded, dropped pulses, the state still goes to DRIVE, and stroke_count is unchanged.
- Result write, on a single edge:
  - ratio←quotient, ratio_valid←1, stroke_count+1.
  - If unprimed: all N entries ← quotient, sum←N·quotient, primed←1.
  - Otherwise: the oldest entry is replaced through a circular pointer, and sum←sum−oldest+quotient.
  - sum is 32+AVG_LOG2 bits. avg_ratio = sum>>AVG_LOG2, registered on the same edge.
- Phase counting continues during division.

## Timing
- Stroke completion at edge t: busy=1 after edges t..t+Q−1, then the result is written at edge t+Q.
- After edge t+Q: ratio, avg_ratio and stroke_count are updated, ratio_valid=1 for one cycle, and busy=0.
- A stroke completing at edge t+Q or later is accepted.
- on_drive follows the state register. It is high from the edge that samples start_drive.
- dropped is high for the cycle after the completing edge.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
- Defaults, basic ratio: start_drive, start_recovery 10 edges later, start_drive 20 edges later. Required: busy for 24 cycles, then ratio=0x200, avg_ratio=0x200, ratio_valid pulse, stroke_count=1.
- Averaging (AVG_LOG2=2): after the stroke above, drive 10 / recovery 30. Required: ratio=0x300 and avg_ratio=(3·512+768)/4=576=0x240. Add further strokes with recovery 30; after the 4th such stroke avg_ratio=0x300.
- Timeout (COUNT_W=4): start_drive, start_recovery after 3 edges, then no pulse. Required: at rec_cnt=15 state=IDLE, overflow=1, no ratio_valid, stroke_count unchanged. The next stroke re-primes, so avg equals ratio.
- Simultaneous and ignored pulses: both pulses high in IDLE gives DRIVE. Both high in DRIVE gives RECOVERY. start_recovery repeated in RECOVERY does not restart rec_cnt. A start_drive during DRIVE is ignored.
- Drop: complete a stroke, then start_recovery and start_drive within 20 edges. Required: dropped pulse, only one ratio_valid, stroke_count=1.
- Reset mid-division: assert reset_n=0 for one edge while busy. Required: every output is 0 at the next cycle, no ratio_valid follows, and the next stroke primes the buffer.

Source files
------------

// File: rtl/stroke_ratio_tracker.sv
// Drive/recovery phase tracker for the erg datapath: times each stroke, divides recovery by drive
// with a bit-serial restoring divider and keeps a moving average of the last 2^AVG_LOG2 ratios.
module stroke_ratio_tracker #(
    parameter int COUNT_W  = 16,
    parameter int FRAC_W   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic        count_clock,
    input  logic        reset_n,
    input  logic        start_drive,
    input  logic        start_recovery,
    output logic [31:0] ratio,
    output logic [31:0] avg_ratio,
    output logic        ratio_valid,
    output logic [15:0] stroke_count,
    output logic        on_drive,
    output logic        busy,
    output logic        overflow,
    output logic        dropped,
    output logic [1:0]  state_dbg
);
    localparam int Q     = COUNT_W + FRAC_W;
    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = 32 + AVG_LOG2;
    localparam int BC_W  = $clog2(Q) + 1;
    localparam logic [COUNT_W-1:0] CNT_LAST = {{(COUNT_W-1){1'b1}}, 1'b0};
    localparam logic [BC_W-1:0]    LAST_BIT = BC_W'(Q - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRIVE    = 2'd1,
        S_RECOVERY = 2'd2
    } phase_t;

    phase_t              state;
    logic [COUNT_W-1:0]  drive_cnt;
    logic [COUNT_W-1:0]  rec_cnt;
    logic [COUNT_W-1:0]  drive_len;
    logic [COUNT_W-1:0]  divisor;
    logic [COUNT_W-1:0]  rem;
    logic [Q-1:0]        dividend;
    logic [Q-1:0]        quot;
    logic [BC_W-1:0]     bit_cnt;
    logic [31:0]         hist [N];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [SUM_W-1:0]    sum;
    logic                primed;

    logic                stroke_end;
    logic                timeout_hit;
    logic                last_step;
    logic                accept;
    logic [COUNT_W:0]    trial;
    logic                trial_ge;
    logic [COUNT_W-1:0]  rem_next;
    logic [Q-1:0]        quot_next;
    logic [31:0]         q_ext;
    logic [SUM_W-1:0]    sum_next;

    assign state_dbg = state;

    // ratio_valid is a one-cycle strobe with no back-pressure: ratio, avg_ratio and
    // stroke_count change on the same edge that raises it and hold until the next strobe.
    always_comb begin
        stroke_end  = (state == S_RECOVERY) && start_drive;
        timeout_hit = ((state == S_DRIVE) && !start_recovery && (drive_cnt == CNT_LAST)) ||
                      ((state == S_RECOVERY) && !start_drive && (rec_cnt == CNT_LAST));
        last_step   = busy && (bit_cnt == LAST_BIT);
        // The final divide step frees the divider on the same edge, so a stroke ending then is kept.
        accept      = stroke_end && (!busy || last_step);
        trial       = {rem, dividend[Q-1]};
        trial_ge    = (trial >= {1'b0, divisor});
        rem_next    = trial_ge ? COUNT_W'(trial - {1'b0, divisor}) : COUNT_W'(trial);
        quot_next   = {quot[Q-2:0], trial_ge};
        q_ext       = 32'(quot_next);
        if (primed) begin
            sum_next = sum - SUM_W'(hist[wr_ptr]) + SUM_W'(q_ext);
        end else begin
            sum_next = SUM_W'(q_ext) << AVG_LOG2;
        end
    end

    always_ff @(posedge count_clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            drive_cnt <= '0;
            rec_cnt   <= '0;
            drive_len <= '0;
            on_drive  <= 1'b0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            dropped <= stroke_end && !accept;
            case (state)
                S_IDLE: begin
                    if (start_drive) begin
                        state     <= S_DRIVE;
                        drive_cnt <= COUNT_W'(1);
                        on_drive  <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (start_recovery) begin
                        state     <= S_RECOVERY;
                        rec_cnt   <= COUNT_W'(1);
                        drive_len <= drive_cnt;
                        on_drive  <= 1'b0;
                    end else begin
                        drive_cnt <= drive_cnt + COUNT_W'(1);
                        if (timeout_hit) begin
                            state    <= S_IDLE;
                            on_drive <= 1'b0;
                            overflow <= 1'b1;
                        end
                    end
                end
                S_RECOVERY: begin
                    if (start_drive) begin
                        state     <= S_DRIVE;
                        drive_cnt <= COUNT_W'(1);
                        on_drive  <= 1'b1;
                    end else begin
                        rec_cnt <= rec_cnt + COUNT_W'(1);
                        if (timeout_hit) begin
                            state    <= S_IDLE;
                            on_drive <= 1'b0;
                            overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    on_drive <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge count_clock) begin
        if (!reset_n) begin
            busy         <= 1'b0;
            bit_cnt      <= '0;
            divisor      <= '0;
            rem          <= '0;
            dividend     <= '0;
            quot         <= '0;
            ratio        <= '0;
            avg_ratio    <= '0;
            ratio_valid  <= 1'b0;
            stroke_count <= '0;
            sum          <= '0;
            wr_ptr       <= '0;
            primed       <= 1'b0;
            for (int i = 0; i < N; i++) hist[i] <= '0;
        end else begin
            ratio_valid <= 1'b0;
            if (busy) begin
                rem      <= rem_next;
                quot     <= quot_next;
                dividend <= {dividend[Q-2:0], 1'b0};
                bit_cnt  <= bit_cnt + BC_W'(1);
                if (last_step) begin
                    busy         <= 1'b0;
                    ratio        <= q_ext;
                    ratio_valid  <= 1'b1;
                    stroke_count <= stroke_count + 16'd1;
                    sum          <= sum_next;
                    avg_ratio    <= 32'(sum_next >> AVG_LOG2);
                    if (primed) begin
                        hist[wr_ptr] <= q_ext;
                        wr_ptr       <= wr_ptr + AVG_LOG2'(1);
                    end else begin
                        for (int i = 0; i < N; i++) hist[i] <= q_ext;
                        wr_ptr <= '0;
                        primed <= 1'b1;
                    end
                end
            end
            if (accept) begin
                busy     <= 1'b1;
                bit_cnt  <= '0;
                rem      <= '0;
                quot     <= '0;
                dividend <= {rec_cnt, {FRAC_W{1'b0}}};
                divisor  <= drive_len;
            end
            // A timed-out stroke breaks the cadence, so the next result restarts the average.
            if (timeout_hit) primed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stroke_ratio_tracker.sv
// Bench for stroke_ratio_tracker: a default instance (A) and a COUNT_W=4 instance (B) run in
// lockstep against a timestamp-based model, plus directed tables and corner sequences.
module tb_stroke_ratio_tracker;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, sd_a, sr_a, rst_b, sd_b, sr_b;
    logic [31:0] ratio_a, avg_a, ratio_b, avg_b;
    logic        valid_a, on_drive_a, busy_a, ovf_a, drop_a;
    logic        valid_b, on_drive_b, busy_b, ovf_b, drop_b;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  st_a, st_b;

    stroke_ratio_tracker dut_a (
        .count_clock(clk), .reset_n(rst_a), .start_drive(sd_a), .start_recovery(sr_a),
        .ratio(ratio_a), .avg_ratio(avg_a), .ratio_valid(valid_a), .stroke_count(cnt_a),
        .on_drive(on_drive_a), .busy(busy_a), .overflow(ovf_a), .dropped(drop_a),
        .state_dbg(st_a)
    );

    stroke_ratio_tracker #(.COUNT_W(4)) dut_b (
        .count_clock(clk), .reset_n(rst_b), .start_drive(sd_b), .start_recovery(sr_b),
        .ratio(ratio_b), .avg_ratio(avg_b), .ratio_valid(valid_b), .stroke_count(cnt_b),
        .on_drive(on_drive_b), .busy(busy_b), .overflow(ovf_b), .dropped(drop_b),
        .state_dbg(st_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned n_edge = 0;
    int valid_cnt [2];
    int drop_cnt  [2];
    int print_cnt [2];

    // Reference model: phase start timestamps, busy-until edge, last-four history.
    int unsigned m_maxc [2];
    int unsigned m_q    [2];
    int          m_st   [2];
    int unsigned m_t0   [2];
    int unsigned m_t1   [2];
    int unsigned m_busy_end [2];
    bit          m_pend [2];
    logic [31:0] m_pend_q [2];
    bit          m_primed [2];
    logic [31:0] m_hist [2][4];
    logic [31:0] e_ratio [2];
    logic [31:0] e_avg   [2];
    logic [15:0] e_cnt   [2];
    bit          e_valid [2];
    bit          e_drop  [2];
    bit          e_ovf   [2];

    typedef struct {
        int unsigned drv;
        int unsigned rec;
        logic [31:0] ratio;
        logic [31:0] avg;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [6];
    int   tbl_idx = 0;
    bit   tbl_on  = 1'b0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, got, exp, n_edge);
        end
    endfunction

    function automatic void timeout_model(int i);
        m_st[i]     = 0;
        e_ovf[i]    = 1'b1;
        m_primed[i] = 1'b0;
    endfunction

    function automatic void model_step(int i, bit rstn, bit sd, bit sr);
        longint unsigned drv, rec, s;
        if (!rstn) begin
            m_st[i] = 0; m_pend[i] = 1'b0; m_busy_end[i] = 0; m_primed[i] = 1'b0;
            e_ratio[i] = '0; e_avg[i] = '0; e_cnt[i] = '0;
            e_valid[i] = 1'b0; e_drop[i] = 1'b0; e_ovf[i] = 1'b0;
            for (int k = 0; k < 4; k++) m_hist[i][k] = '0;
        end else begin
            e_valid[i] = 1'b0;
            e_drop[i]  = 1'b0;
            if (m_pend[i] && n_edge == m_busy_end[i]) begin
                m_pend[i]  = 1'b0;
                e_ratio[i] = m_pend_q[i];
                e_valid[i] = 1'b1;
                e_cnt[i]   = e_cnt[i] + 16'd1;
                if (!m_primed[i]) begin
                    for (int k = 0; k < 4; k++) m_hist[i][k] = m_pend_q[i];
                end else begin
                    for (int k = 0; k < 3; k++) m_hist[i][k] = m_hist[i][k+1];
                    m_hist[i][3] = m_pend_q[i];
                end
                m_primed[i] = 1'b1;
                s = 0;
                for (int k = 0; k < 4; k++) s += longint'(m_hist[i][k]);
                e_avg[i] = 32'(s / 4);
            end
            case (m_st[i])
                0: if (sd) begin m_st[i] = 1; m_t0[i] = n_edge; end
                1: begin
                    if (sr) begin m_st[i] = 2; m_t1[i] = n_edge; end
                    else if (n_edge - m_t0[i] == m_maxc[i] - 1) timeout_model(i);
                end
                default: begin
                    if (sd) begin
                        drv = longint'(m_t1[i] - m_t0[i]);
                        rec = longint'(n_edge - m_t1[i]);
                        if (n_edge >= m_busy_end[i]) begin
                            m_pend[i]     = 1'b1;
                            m_pend_q[i]   = 32'((rec << FRAC) / drv);
                            m_busy_end[i] = n_edge + m_q[i];
                        end else begin
                            e_drop[i] = 1'b1;
                        end
                        m_st[i] = 1;
                        m_t0[i] = n_edge;
                    end else if (n_edge - m_t1[i] == m_maxc[i] - 1) begin
                        timeout_model(i);
                    end
                end
            endcase
        end
    endfunction

    function automatic void check_cycle(int i);
        logic [86:0] act, exp;
        if (i == 0) act = {st_a, on_drive_a, busy_a, ovf_a, drop_a, valid_a, cnt_a, ratio_a, avg_a};
        else        act = {st_b, on_drive_b, busy_b, ovf_b, drop_b, valid_b, cnt_b, ratio_b, avg_b};
        exp = {2'(m_st[i]), (m_st[i] == 1), (n_edge < m_busy_end[i]), e_ovf[i], e_drop[i],
               e_valid[i], e_cnt[i], e_ratio[i], e_avg[i]};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (print_cnt[i] < 20) begin
                print_cnt[i]++;
                $display("FAIL cycle_%0d edge %0d: got {st,drv,busy,ovf,drop,vld,cnt,ratio,avg}=0x%0h expected 0x%0h",
                         i, n_edge, act, exp);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        n_edge++;
        model_step(0, rst_a, sd_a, sr_a);
        model_step(1, rst_b, sd_b, sr_b);
        #1;
        check_cycle(0);
        check_cycle(1);
        if (valid_a) begin
            valid_cnt[0]++;
            if (tbl_on && tbl_idx < 6) begin
                check("tbl_ratio", 64'(ratio_a), 64'(tbl[tbl_idx].ratio));
                check("tbl_avg",   64'(avg_a),   64'(tbl[tbl_idx].avg));
                check("tbl_count", 64'(cnt_a),   64'(tbl[tbl_idx].cnt));
                tbl_idx++;
            end
        end
        if (valid_b) valid_cnt[1]++;
        if (drop_a)  drop_cnt[0]++;
        if (drop_b)  drop_cnt[1]++;
        sd_a = 1'b0; sr_a = 1'b0; sd_b = 1'b0; sr_b = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
    endtask

    task automatic stroke(int i, int unsigned drv, int unsigned rec);
        repeat (drv - 1) tick();
        if (i == 0) sr_a = 1'b1; else sr_b = 1'b1;
        tick();
        repeat (rec - 1) tick();
        if (i == 0) sd_a = 1'b1; else sd_b = 1'b1;
        tick();
    endtask

    task automatic wait_valid(int i, int budget, string name);
        int start;
        start = valid_cnt[i];
        for (int k = 0; k < budget; k++) begin
            if (valid_cnt[i] != start) break;
            tick();
        end
        check(name, 64'(valid_cnt[i] != start), 64'd1);
    endtask

    initial begin
        int base_v, base_d, pa, pb;
        m_maxc[0] = 65535; m_q[0] = 24;
        m_maxc[1] = 15;    m_q[1] = 12;
        for (int i = 0; i < 2; i++) begin
            valid_cnt[i] = 0; drop_cnt[i] = 0; print_cnt[i] = 0; m_busy_end[i] = 0;
        end
        tbl[0] = '{drv: 10, rec: 20, ratio: 32'h200, avg: 32'h200, cnt: 16'd1};
        tbl[1] = '{drv: 10, rec: 30, ratio: 32'h300, avg: 32'h240, cnt: 16'd2};
        tbl[2] = '{drv: 10, rec: 30, ratio: 32'h300, avg: 32'h280, cnt: 16'd3};
        tbl[3] = '{drv: 10, rec: 30, ratio: 32'h300, avg: 32'h2C0, cnt: 16'd4};
        tbl[4] = '{drv: 10, rec: 30, ratio: 32'h300, avg: 32'h300, cnt: 16'd5};
        tbl[5] = '{drv: 7,  rec: 20, ratio: 32'h2DB, avg: 32'h2F6, cnt: 16'd6};

        sd_a = 1'b0; sr_a = 1'b0; sd_b = 1'b0; sr_b = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        check("rst_ratio", 64'(ratio_a), 64'd0);
        check("rst_avg",   64'(avg_a),   64'd0);
        check("rst_flags", 64'({valid_a, on_drive_a, busy_a, ovf_a, drop_a}), 64'd0);
        check("rst_count", 64'(cnt_a), 64'd0);
        check("rst_state", 64'(st_a),  64'd0);

        // Table-driven strokes on A, then a quick stroke that must be dropped.
        tbl_on = 1'b1;
        sd_a = 1'b1;
        tick();
        check("on_drive_first_edge", 64'(on_drive_a), 64'd1);
        for (int i = 0; i < 6; i++) stroke(0, tbl[i].drv, tbl[i].rec);
        base_d = drop_cnt[0];
        stroke(0, 5, 5);
        for (int k = 0; k < 100 && tbl_idx < 6; k++) tick();
        check("table_done", 64'(tbl_idx), 64'd6);
        tbl_on = 1'b0;
        repeat (30) tick();
        check("drop_pulses", 64'(drop_cnt[0] - base_d), 64'd1);
        check("valid_total", 64'(valid_cnt[0]), 64'd6);
        check("count_after_drop", 64'(cnt_a), 64'd6);

        // Reset while the divider is running.
        stroke(0, 10, 10);
        repeat (5) tick();
        check("busy_before_reset", 64'(busy_a), 64'd1);
        rst_a = 1'b0;
        tick();
        check("midrst_outputs",
              64'({ratio_a, 32'd0} | 64'(avg_a)), 64'd0);
        check("midrst_flags", 64'({valid_a, on_drive_a, busy_a, ovf_a, drop_a, st_a, cnt_a}), 64'd0);
        base_v = valid_cnt[0];
        repeat (30) tick();
        check("midrst_no_valid", 64'(valid_cnt[0] - base_v), 64'd0);
        sd_a = 1'b1;
        tick();
        stroke(0, 10, 30);
        wait_valid(0, 40, "reprime_valid");
        check("reprime_ratio", 64'(ratio_a), 64'h300);
        check("reprime_avg",   64'(avg_a),   64'h300);
        check("reprime_count", 64'(cnt_a),   64'd1);

        // Timeout on the narrow-counter instance.
        sd_b = 1'b1;
        tick();
        stroke(1, 4, 8);
        repeat (2) tick();
        sr_b = 1'b1;
        tick();
        repeat (13) tick();
        check("pre_timeout_state", 64'(st_b), 64'd2);
        tick();
        check("timeout_state", 64'(st_b), 64'd0);
        check("timeout_ovf",   64'(ovf_b), 64'd1);
        check("timeout_count", 64'(cnt_b), 64'd1);
        check("timeout_valids", 64'(valid_cnt[1]), 64'd1);
        check("timeout_ratio", 64'(ratio_b), 64'h200);

        // Simultaneous and ignored pulses, also the re-priming stroke after timeout.
        sd_b = 1'b1; sr_b = 1'b1;
        tick();
        check("both_in_idle", 64'(st_b), 64'd1);
        repeat (2) tick();
        sd_b = 1'b1;
        tick();
        check("drive_ignores_sd", 64'(st_b), 64'd1);
        tick();
        sd_b = 1'b1; sr_b = 1'b1;
        tick();
        check("both_in_drive", 64'(st_b), 64'd2);
        repeat (2) tick();
        sr_b = 1'b1;
        tick();
        check("rec_ignores_sr", 64'(st_b), 64'd2);
        tick();
        sd_b = 1'b1;
        tick();
        wait_valid(1, 20, "simul_valid");
        check("simul_ratio", 64'(ratio_b), 64'h100);
        check("simul_avg",   64'(avg_b),   64'h100);
        check("simul_count", 64'(cnt_b),   64'd2);

        // Random pulses and occasional resets on both instances.
        pa = 5; pb = 8;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                pa = $urandom_range(2, 15);
                pb = $urandom_range(3, 25);
            end
            sd_a  = ($urandom_range(0, 99) < pa);
            sr_a  = ($urandom_range(0, 99) < pa);
            sd_b  = ($urandom_range(0, 99) < pb);
            sr_b  = ($urandom_range(0, 99) < pb);
            rst_a = ($urandom_range(0, 999) != 0);
            rst_b = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
